fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register.
- Owns the PC and issues word requests to instruction memory over a req/ready handshake.
- Presents the fetched instruction and its PC to decode. Decode slices immediates from this instruction and sign-extends them.
- Consumes the sign-extended B-type offset plus a taken flag from the branch logic to redirect the PC and flush.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_skid_buffer.sv | 35 +++
 rtl/fetch_stage.sv | 146 ++++++++++++++
 tb/tb_fetch_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by the fetch stage and its skid buffer.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC   = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding register.
// Catches a response that arrives while decode holds IF/ID.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            load,
  input  logic            pop,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  // Flush beats a fill; a fill beats a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem handshake and IF/ID register.
// Redirects on a taken branch and drops any stale response.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  input  logic [31:0] branch_offset,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid
);

  import fetch_pkg::*;

  fetch_state_t state, state_nx;

  logic [31:0] pc, pc_nx, addr_nx;
  logic [31:0] target;
  logic        xfer, resp_ok, hold;
  logic        skid_valid, skid_load, skid_pop;
  logic        skid_valid_nx, valid_nx, can_issue;
  logic [31:0] skid_instr, skid_pc;

  assign target = (branch_pc + (branch_offset << 1))
                & 32'hFFFF_FFFC;

  assign imem_req  = (state != IDLE);
  assign xfer      = imem_req && imem_ready;
  assign resp_ok   = (state == BUSY) && xfer
                  && !branch_taken;
  assign hold      = stall && if_id_valid;
  assign skid_load = resp_ok && hold;
  assign skid_pop  = skid_valid && !hold
                  && !branch_taken;

  // Post-update view of IF/ID and skid for issue decisions.
  always_comb begin
    valid_nx      = 1'b0;
    skid_valid_nx = skid_valid;
    if (branch_taken) begin
      skid_valid_nx = 1'b0;
    end else if (hold) begin
      valid_nx      = 1'b1;
      skid_valid_nx = skid_valid || skid_load;
    end else begin
      valid_nx      = skid_valid || resp_ok;
      skid_valid_nx = 1'b0;
    end
  end

  assign can_issue = !skid_valid_nx
                  && !(stall && valid_nx);

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (branch_taken),
    .load       (skid_load),
    .pop        (skid_pop),
    .load_instr (imem_rdata),
    .load_pc    (imem_addr),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  // Fetch FSM next state, next PC and next request address.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    addr_nx  = imem_addr;
    unique case (state)
      IDLE: begin
        if (branch_taken) begin
          pc_nx = target;
        end else if (can_issue) begin
          addr_nx  = pc;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (branch_taken) begin
          pc_nx    = target;
          state_nx = xfer ? IDLE : DROP;
        end else if (xfer) begin
          pc_nx = pc + PC_INC;
          if (can_issue) addr_nx = pc + PC_INC;
          else state_nx = IDLE;
        end
      end
      DROP: begin
        if (branch_taken) pc_nx = target;
        if (xfer) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM, PC and request address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      imem_addr <= addr_nx;
    end
  end

  // IF/ID register: flush, then hold, then skid, then memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
    end else if (branch_taken) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else if (hold) begin
      if_id_valid <= if_id_valid;
    end else if (skid_valid) begin
      if_id_valid <= 1'b1;
      if_id_instr <= skid_instr;
      if_id_pc    <= skid_pc;
    end else if (resp_ok) begin
      if_id_valid <= 1'b1;
      if_id_instr <= imem_rdata;
      if_id_pc    <= imem_addr;
    end else begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table, async reset,
// then random traffic against a PC-stream reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] branch_offset;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;

  int n_cmp;
  int n_fail;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_pc     (branch_pc),
    .branch_offset (branch_offset),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: word at address A holds A + 0x100.
  assign imem_rdata = imem_addr + 32'h100;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] bpc;
    logic [31:0] boff;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic add(input logic s, input logic b,
                     input logic [31:0] bp,
                     input logic [31:0] bo,
                     input logic r, input logic q,
                     input logic [31:0] a,
                     input logic v,
                     input logic [31:0] p,
                     input logic [31:0] ins);
    vec_t t;
    t.stall = s; t.br = b; t.bpc = bp; t.boff = bo;
    t.rdy = r; t.req = q; t.addr = a; t.valid = v;
    t.pc = p; t.instr = ins;
    tv.push_back(t);
  endtask

  function automatic logic [31:0] model_target(
      input logic [31:0] bpc, input logic [31:0] boff);
    logic [31:0] t;
    t = bpc + boff * 32'd2;
    return t - (t % 32'd4);
  endfunction

  initial begin
    logic        exp_flush;
    logic        p_req, p_rdy;
    logic [31:0] p_addr;
    logic [31:0] exp_pc;
    int          accepts;

    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_pc = '0;
    branch_offset = '0;
    imem_ready = 1'b1;

    // stall,br,bpc,boff,rdy | req,addr,valid,pc,instr
    add(0,0,0,0,1, 0,32'h00,0,0,NOP);
    add(0,0,0,0,1, 1,32'h00,0,0,NOP);
    add(0,0,0,0,1, 1,32'h04,1,32'h00,32'h100);
    add(0,0,0,0,1, 1,32'h08,1,32'h04,32'h104);
    add(1,0,0,0,1, 1,32'h0C,1,32'h08,32'h108);
    add(1,0,0,0,1, 0,32'h0C,1,32'h08,32'h108);
    add(1,0,0,0,1, 0,32'h0C,1,32'h08,32'h108);
    add(0,0,0,0,1, 0,32'h0C,1,32'h08,32'h108);
    add(0,0,0,0,1, 1,32'h10,1,32'h0C,32'h10C);
    add(0,1,32'h20,32'hFFFF_FFF8,1,
        1,32'h14,1,32'h10,32'h110);
    add(0,0,0,0,1, 0,32'h14,0,0,NOP);
    add(0,0,0,0,1, 1,32'h10,0,0,NOP);
    add(0,0,0,0,0, 1,32'h14,1,32'h10,32'h110);
    add(0,1,32'h30,32'h8,0, 1,32'h14,0,0,NOP);
    add(0,0,0,0,0, 1,32'h14,0,0,NOP);
    add(0,0,0,0,0, 1,32'h14,0,0,NOP);
    add(0,0,0,0,1, 1,32'h14,0,0,NOP);
    add(0,0,0,0,1, 0,32'h14,0,0,NOP);
    add(0,0,0,0,1, 1,32'h40,0,0,NOP);
    add(1,0,0,0,1, 1,32'h44,1,32'h40,32'h140);
    add(1,1,32'h100,32'h10,1,
        0,32'h44,1,32'h40,32'h140);
    add(0,0,0,0,1, 0,32'h44,0,0,NOP);
    add(0,0,0,0,1, 1,32'h120,0,0,NOP);
    add(0,0,0,0,1, 1,32'h124,1,32'h120,32'h220);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 0; i < tv.size(); i++) begin
      stall        = tv[i].stall;
      branch_taken = tv[i].br;
      branch_pc    = tv[i].bpc;
      branch_offset = tv[i].boff;
      imem_ready   = tv[i].rdy;
      chk($sformatf("v%0d req", i), 32'(imem_req),
          32'(tv[i].req));
      chk($sformatf("v%0d addr", i), imem_addr, tv[i].addr);
      chk($sformatf("v%0d valid", i), 32'(if_id_valid),
          32'(tv[i].valid));
      chk($sformatf("v%0d instr", i), if_id_instr,
          tv[i].instr);
      if (tv[i].valid)
        chk($sformatf("v%0d pc", i), if_id_pc, tv[i].pc);
      @(posedge clk);
      #1;
    end

    // Async reset while BUSY: outputs clear before any edge.
    stall = 1'b0;
    branch_taken = 1'b0;
    imem_ready = 1'b1;
    chk("pre_rst busy", 32'(imem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst req", 32'(imem_req), 32'd0);
    chk("arst addr", imem_addr, 32'h0);
    chk("arst valid", 32'(if_id_valid), 32'd0);
    chk("arst instr", if_id_instr, NOP);
    chk("arst pc", if_id_pc, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel req0", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    chk("rel req1", 32'(imem_req), 32'd1);
    chk("rel addr", imem_addr, 32'h0);

    // Random traffic: decode must see an unbroken PC stream.
    exp_pc    = 32'h0;
    exp_flush = 1'b0;
    p_req     = 1'b0;
    p_rdy     = 1'b0;
    p_addr    = '0;
    accepts   = 0;
    for (int c = 0; c < 4000; c++) begin
      stall        = ($urandom_range(3) == 0);
      imem_ready   = ($urandom_range(2) != 0);
      branch_taken = ($urandom_range(39) == 0);
      branch_pc    = {20'h0, 2'($urandom_range(3)),
                      8'($urandom), 2'b00};
      branch_offset = 32'($urandom_range(255)) - 32'd128;

      if (exp_flush)
        chk("flush valid", 32'(if_id_valid), 32'd0);
      if (!if_id_valid)
        chk("idle nop", if_id_instr, NOP);
      if (p_req && !p_rdy) begin
        chk("hold req", 32'(imem_req), 32'd1);
        chk("hold addr", imem_addr, p_addr);
      end
      if (if_id_valid && !stall) begin
        chk("rnd pc", if_id_pc, exp_pc);
        chk("rnd instr", if_id_instr, exp_pc + 32'h100);
        exp_pc = exp_pc + 32'd4;
        accepts++;
      end
      if (branch_taken)
        exp_pc = model_target(branch_pc, branch_offset);
      exp_flush = branch_taken;
      p_req  = imem_req;
      p_rdy  = imem_ready;
      p_addr = imem_addr;
      @(posedge clk);
      #1;
    end
    chk("progress", 32'(accepts > 800), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
